// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V byte/half/word loads and stores into whole-word memory accesses.
// Define MISALIGN_TRAP_EN to flag misaligned halfword/word accesses as errors.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_merged, r_rdata;
  logic [2:0]  r_f3;
  logic        r_we, r_err;
  logic        w_f3_bad, w_oor, w_mis, w_bad, w_sub;
  logic [4:0]  w_lane;
  logic [31:0] w_sh, w_load, w_merged;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_f3_bad = r_we ? (r_f3 > 3'd2) : (r_f3 == 3'b011 || r_f3[2:1] == 2'b11);
  assign w_oor    = r_addr[31:2] >= 30'(MEM_WORDS);
`ifdef MISALIGN_TRAP_EN
  assign w_mis = (r_f3[1:0] == 2'b01 && r_addr[0]) || (r_f3[1:0] == 2'b10 && r_addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  assign w_bad  = w_f3_bad || w_oor || w_mis;
  assign w_sub  = r_f3[1:0] != 2'b10;
  assign w_lane = {r_addr[1:0], 3'b000};
  assign w_sh   = mem_rd >> w_lane;
  assign w_b    = w_sh[7:0];
  assign w_h    = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
  assign w_load = r_f3[1:0] == 2'b00 ? {{24{w_b[7] & ~r_f3[2]}}, w_b} :
                  r_f3[1:0] == 2'b01 ? {{16{w_h[15] & ~r_f3[2]}}, w_h} : mem_rd;
  // Sub-word store: splice the new byte/halfword into the word just read.
  assign w_merged = r_f3[0] ? (r_addr[1] ? {r_wdata[15:0], mem_rd[15:0]} : {mem_rd[31:16], r_wdata[15:0]})
                            : (mem_rd & ~(32'hFF << w_lane)) | ({24'b0, r_wdata[7:0]} << w_lane);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE   ? (req_valid ? ACCESS : IDLE) :
             r_state == ACCESS ? ((r_we && !w_bad && w_sub) ? WRITE : RESP) :
             r_state == WRITE  ? RESP : IDLE;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_f3     <= '0;
      r_we     <= 1'b0;
      r_merged <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_f3    <= req_funct3;
        r_we    <= req_we;
      end
      if (r_state == ACCESS) begin
        r_err    <= w_bad;
        r_rdata  <= (w_bad || r_we) ? 32'b0 : w_load;
        r_merged <= w_merged;
      end
    end
  end
  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_state == RESP;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_a      = {r_addr[31:2], 2'b00};
  assign mem_we     = r_state == WRITE || (r_state == ACCESS && r_we && !w_bad && !w_sub);
  assign mem_wd     = r_state == WRITE ? r_merged : (mem_we ? r_wdata : 32'b0);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a word memory model.
module tb_load_store_unit;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  int cyc = 0, wr_cnt = 0, wr_base = 0, resp_cnt = 0, errors = 0, checks = 0;
  typedef struct {logic [31:0] rd; logic err; int lat; int wr; int acc;} exp_t;
  exp_t exp_q[$];

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd));

  always #5 CLK = ~CLK;
  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) begin
      mem[mem_a[11:2]] <= mem_wd;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge CLK) begin
    if (!RESET && resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", resp_rdata, e.rd);
        chk("err", {31'b0, resp_err}, {31'b0, e.err});
        chk("latency", cyc + 1 - e.acc, e.lat);
        chk("writes", wr_cnt - wr_base, e.wr);
        wr_base = wr_cnt;
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input logic err, input int lat, input int wr);
    int g, n;
    @(negedge CLK);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge CLK); g++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    exp_q.push_back('{rd, err, lat, wr, cyc + 1});
    n = resp_cnt;
    #1 req_valid = 1'b0;
    g = 0;
    while (resp_cnt == n && g < 20) begin @(negedge CLK); g++; end
    if (resp_cnt == n) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no resp_valid expected a response within 20 cycles");
    end
  endtask

  initial begin
    #3;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    preload(10'd4, 32'h8081_F0FF);
    req(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FF81, 1'b0, 2, 0);
    req(1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_0081, 1'b0, 2, 0);
    req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 0);
    req(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 0);
    req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 1'b0, 2, 0);
    req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_F0FF, 1'b0, 2, 0);
    req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8081_F0FF, 1'b0, 2, 0);
`ifdef MISALIGN_TRAP_EN
    req(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 2, 0);
`else
    req(1'b0, 3'b010, 32'h13, 32'h0, 32'h8081_F0FF, 1'b0, 2, 0);
`endif

    preload(10'd4, 32'h1122_3344);
    req(1'b1, 3'b000, 32'h11, 32'hAA, 32'h0, 1'b0, 3, 1);
    chk("mem_sb", mem[4], 32'h1122_AA44);
    preload(10'd4, 32'h0);
    req(1'b1, 3'b001, 32'h12, 32'hBEEF, 32'h0, 1'b0, 3, 1);
    chk("mem_sh", mem[4], 32'hBEEF_0000);
    req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
    chk("mem_sw", mem[4], 32'hDEAD_BEEF);

    req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0);
    req(1'b1, 3'b010, 32'h1000, 32'h1234_5678, 32'h0, 1'b1, 2, 0);
    req(1'b1, 3'b011, 32'h10, 32'h1234_5678, 32'h0, 1'b1, 2, 0);
    chk("mem_after_err", mem[4], 32'hDEAD_BEEF);
    chk("mem0_after_err", mem[0], 32'h0);

    preload(10'd4, 32'h1122_3344);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("sb_access_we", {31'b0, mem_we}, 32'd0);
    @(negedge CLK);
    chk("sb_write_we", {31'b0, mem_we}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem", mem[4], 32'h1122_3344);
    req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2, 0);

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-addressed data memory: 32-bit words, combinational read, write on CLK rising edge when WE is high.
- Converts RISC-V byte, halfword and word loads and stores into whole-word memory accesses.
- Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended.
- Uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- MEM_WORDS, 1024: words in the attached memory. A request with word index (addr[31:2]) >= MEM_WORDS is out of range.

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101
  - stores: SB=000, SH=001, SW=010
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request was illegal; qualified by resp_valid
- mem_a  output  32  memory address; bits [1:0] always 0
- mem_wd  output  32  memory write data
- mem_we  output  1  memory write enable
- mem_rd  input  32  memory read data, combinational from mem_a

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0
  - mem_we = 0, mem_a = 0, mem_wd = 0
  - Reset during ACCESS or WRITE aborts the request; no write occurs after RESET rises.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1: latch addr, we, funct3 and wdata, then go to ACCESS.
  - Request inputs are ignored in every other state.
- Error check (combinational on latched fields, evaluated in ACCESS). The request is illegal if either holds:
  - funct3 is undefined: load funct3 of 011, 110 or 111; store funct3 other than 000, 001 or 010.
  - the word index is >= MEM_WORDS.
- ACCESS:
  - mem_a = {addr[31:2], 2'b00}.
  - Illegal: mem_we = 0; latch err = 1 and rdata = 0; go to RESP.
  - Load:
    - Byte lane = addr[1:0]; halfword lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
    - Register the result into resp_rdata; go to RESP.
  - SW: mem_we = 1 and mem_wd = wdata this cycle; go to RESP.
  - SB/SH:
    - Capture mem_rd.
    - Build the merged word: replace the byte lane addr[1:0] with wdata[7:0], or the halfword lane addr[1] with wdata[15:0].
    - Go to WRITE.
- WRITE:
  - mem_we = 1, mem_wd = merged word, same mem_a.
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_err hold their latched values.
  - Go to IDLE. resp_rdata and resp_err hold until the next RESP.
  - The core cannot stall the response.
- Latency, counted from the accepting edge to the edge on which resp_valid is sampled:
  - loads and SW: 2 cycles
  - SB/SH: 3 cycles
  - errors: 2 cycles
  - Next request can be accepted on the edge after RESP, giving 1 idle cycle minimum between requests.
- mem_we is 0 outside ACCESS (SW only) and WRITE. A store writes exactly one word.
- Back-to-back: a req_valid held high through RESP is accepted on the first IDLE edge.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, is illegal.
  - Result: resp_err = 1, resp_rdata = 0, no write.
- Undefined:
  - Misalignment is ignored: halfword uses lane addr[1], word ignores addr[1:0].
  - resp_err stays 0 for such requests.

Test Plan:
- Preload word 4 = 0x8081_F0FF; LB addr 0x12 -> resp_rdata 0xFFFF_FF81 at latency 2, resp_err 0. LBU addr 0x12 -> 0x0000_0081.
- Word 4 = 0x1122_3344; SB addr 0x11, wdata 0xAA -> mem_we high only in WRITE, word 4 = 0x1122_AA44, latency 3.
- SH addr 0x12, wdata 0xBEEF on word 4 = 0 -> word 4 = 0xBEEF_0000. SW addr 0x10, wdata 0xDEAD_BEEF -> one write, latency 2.
- Load funct3 011, and SW to addr 0x1000 with MEM_WORDS = 1024 -> resp_err 1, resp_rdata 0, mem_we never high.
- LW addr 0x13 with MISALIGN_TRAP_EN -> resp_err 1, no write. Without the macro -> returns word 4, resp_err 0.
- Assert RESET during WRITE of an SB -> mem_we drops immediately, memory unchanged, resp_valid 0, req_ready 1 after release.
